// File: rtl/vedic_product_accumulator.sv
// Group-sum accumulator behind the pipelined 8x8 Vedic multiplier, with a 2-entry result buffer.
// Define ACC_SATURATE_EN to clamp an overflowing group at 2^ACC_W-1 instead of wrapping.
module vedic_product_accumulator #(
    parameter int unsigned PROD_W    = 16,
    parameter int unsigned ACC_W     = 24,
    parameter int unsigned ACC_COUNT = 8,
    localparam int unsigned CNT_W    = $clog2(ACC_COUNT + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    input  logic [PROD_W-1:0] IN_PROD,
    output logic              IN_READY,
    input  logic              FLUSH,
    output logic              OUT_VALID,
    output logic [ACC_W-1:0]  OUT_SUM,
    output logic [CNT_W-1:0]  OUT_CNT,
    output logic              OUT_OVF,
    input  logic              OUT_READY
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(ACC_COUNT - 1);
`ifdef ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] AccMax = '1;
`endif

    // Running group state
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             pend_q, pend_d;
    logic             in_ready_q, in_ready_d;

    // Result buffer; entry 0 is always the head
    logic [ACC_W-1:0] obuf_sum_q [2];
    logic [ACC_W-1:0] obuf_sum_d [2];
    logic [CNT_W-1:0] obuf_cnt_q [2];
    logic [CNT_W-1:0] obuf_cnt_d [2];
    logic             obuf_ovf_q [2];
    logic             obuf_ovf_d [2];
    logic [1:0]       occ_q, occ_d;

    logic             accept;
    logic             pop;
    logic [ACC_W:0]   sum_ext;
    logic             carry;
    logic [ACC_W-1:0] beat_acc;
    logic [ACC_W-1:0] nxt_acc;
    logic [CNT_W-1:0] nxt_cnt;
    logic             nxt_ovf;
    logic             last_beat;
    logic             flush_req;
    logic             push;

    assign accept = IN_VALID & in_ready_q;
    assign pop    = (occ_q != 2'd0) & OUT_READY;

    assign sum_ext = {1'b0, acc_q} + (ACC_W + 1)'(IN_PROD);
    assign carry   = sum_ext[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, the group stays pinned at full scale until it closes.
    assign beat_acc = (carry | ovf_q) ? AccMax : sum_ext[ACC_W-1:0];
`else
    assign beat_acc = sum_ext[ACC_W-1:0];
`endif

    assign nxt_acc = accept ? beat_acc : acc_q;
    assign nxt_cnt = cnt_q + CNT_W'(accept);
    assign nxt_ovf = ovf_q | (accept & carry);

    // A pending flush keeps requesting until the buffer has room.
    assign last_beat = accept & (cnt_q == LastCnt);
    assign flush_req = (FLUSH | pend_q) & ((cnt_q != '0) | accept);
    assign push      = (last_beat | flush_req) & (occ_q != 2'd2);

    always_comb begin
        acc_d  = nxt_acc;
        cnt_d  = nxt_cnt;
        ovf_d  = nxt_ovf;
        pend_d = pend_q;
        if (push) begin
            acc_d  = '0;
            cnt_d  = '0;
            ovf_d  = 1'b0;
            pend_d = 1'b0;
        end else if (flush_req) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        obuf_sum_d = obuf_sum_q;
        obuf_cnt_d = obuf_cnt_q;
        obuf_ovf_d = obuf_ovf_q;
        occ_d      = occ_q;
        unique case ({push, pop})
            2'b10: begin
                obuf_sum_d[occ_q[0]] = nxt_acc;
                obuf_cnt_d[occ_q[0]] = nxt_cnt;
                obuf_ovf_d[occ_q[0]] = nxt_ovf;
                occ_d                = occ_q + 2'd1;
            end
            2'b01: begin
                obuf_sum_d[0] = obuf_sum_q[1];
                obuf_cnt_d[0] = obuf_cnt_q[1];
                obuf_ovf_d[0] = obuf_ovf_q[1];
                occ_d         = occ_q - 2'd1;
            end
            2'b11: begin
                // Push needs occ != 2 and pop needs occ != 0, so occ is 1 here.
                obuf_sum_d[0] = nxt_acc;
                obuf_cnt_d[0] = nxt_cnt;
                obuf_ovf_d[0] = nxt_ovf;
            end
            default: ;
        endcase
    end

    assign in_ready_d = (occ_d != 2'd2) & ~pend_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b1;
            occ_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                obuf_sum_q[i] <= '0;
                obuf_cnt_q[i] <= '0;
                obuf_ovf_q[i] <= 1'b0;
            end
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
            occ_q      <= occ_d;
            obuf_sum_q <= obuf_sum_d;
            obuf_cnt_q <= obuf_cnt_d;
            obuf_ovf_q <= obuf_ovf_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (occ_q != 2'd0);
    assign OUT_SUM   = obuf_sum_q[0];
    assign OUT_CNT   = obuf_cnt_q[0];
    assign OUT_OVF   = obuf_ovf_q[0];

endmodule
